// File: rtl/dma_pkg.sv
// Shared DMA datapath constants.
// Used by the line FIFO and dma_fsm.
package dma_pkg;

    localparam int CL_SIZE_WIDTH = 512;
    localparam int WORD_SIZE     = 32;

endpackage

// File: rtl/dma_line_fifo.sv
// First-word-fall-through cache-line buffer
// feeding dma_fsm from the host read channel.
module dma_line_fifo #(
    parameter int CL_SIZE_WIDTH = dma_pkg::CL_SIZE_WIDTH,
    parameter int DEPTH         = 8,
    parameter int AF_THRESH     = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [CL_SIZE_WIDTH-1:0]   wr_data,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       rd_en,
    output logic [CL_SIZE_WIDTH-1:0]   rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);

    logic [CL_SIZE_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]              wr_ptr;
    logic [AW:0]              rd_ptr;
    logic                     push_ok;
    logic                     pop_ok;

    // Extra wrap bit lets full and empty be told apart from the pointers.
    assign count       = wr_ptr - rd_ptr;
    assign empty       = (count == '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AF_C);
    assign rd_data     = mem[rd_ptr[AW-1:0]];

    assign push_ok = wr_en & (~full | rd_en);
    assign pop_ok  = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; only the pointers say what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // A fresh error outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !push_ok)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
            if (rd_en && empty)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dma_line_fifo.sv
// Scoreboard bench for dma_line_fifo.
// Expected lines are queued on push and compared on pop.
module tb_dma_line_fifo;

    localparam int W     = 512;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    typedef logic [W-1:0] line_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    line_t       wr_data = '0;
    logic        full;
    logic        almost_full;
    logic        rd_en = 1'b0;
    line_t       rd_data;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;
    logic        clr_err = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    line_t q[$];
    logic  m_ovf = 1'b0;
    logic  m_unf = 1'b0;

    dma_line_fifo #(
        .CL_SIZE_WIDTH(W),
        .DEPTH(DEPTH),
        .AF_THRESH(AF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .almost_full(almost_full),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input line_t got, input line_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        int n;
        n = q.size();
        check({tag, ".count"}, line_t'(count), line_t'(n));
        check({tag, ".empty"}, line_t'(empty), line_t'(n == 0));
        check({tag, ".full"}, line_t'(full), line_t'(n == DEPTH));
        check({tag, ".af"}, line_t'(almost_full), line_t'(n >= AF));
        check({tag, ".ovf"}, line_t'(overflow), line_t'(m_ovf));
        check({tag, ".unf"}, line_t'(underflow), line_t'(m_unf));
    endtask

    task automatic cyc(input logic w, input line_t d,
                       input logic r, input logic c);
        logic wok;
        logic pok;
        logic was_empty;
        was_empty = (q.size() == 0);
        pok = r && !was_empty;
        wok = w && (q.size() != DEPTH || r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        if (pok)
            check("pop_data", rd_data, q[0]);
        @(posedge clk);
        #1;
        if (pok)
            q.delete(0);
        if (wok)
            q.push_back(d);
        if (w && !wok)
            m_ovf = 1'b1;
        else if (c)
            m_ovf = 1'b0;
        if (r && was_empty)
            m_unf = 1'b1;
        else if (c)
            m_unf = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_data = {16{32'hDEAD_BEEF}};
        rd_en   = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    function automatic line_t pat(input int k);
        return {16{32'h5A00_0000 + 32'(k)}};
    endfunction

    initial begin
        line_t a5;
        line_t v1234;
        a5    = {64{8'hA5}};
        v1234 = line_t'(16'h1234);

        do_reset();
        chk_status("reset");

        cyc(1'b1, a5, 1'b0, 1'b0);
        chk_status("push_a5");
        check("a5_head", rd_data, a5);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_status("pop_a5");

        for (int k = 0; k < DEPTH; k++) begin
            cyc(1'b1, pat(k), 1'b0, 1'b0);
            chk_status("fill");
        end
        cyc(1'b1, pat(99), 1'b0, 1'b0);
        chk_status("push_full");
        for (int k = 0; k < DEPTH; k++) begin
            check("order", rd_data, pat(k));
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk_status("drain");
        end

        cyc(1'b0, '0, 1'b0, 1'b1);
        chk_status("clr1");

        for (int k = 0; k < DEPTH; k++)
            cyc(1'b1, pat(100 + k), 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, pat(200 + k), 1'b1, 1'b0);
            chk_status("wr_rd_full");
        end
        while (q.size() != 0)
            cyc(1'b0, '0, 1'b1, 1'b0);
        chk_status("drain2");

        cyc(1'b1, pat(300), 1'b1, 1'b0);
        chk_status("wr_rd_empty");
        check("fwft", rd_data, pat(300));

        for (int k = 1; k < DEPTH; k++)
            cyc(1'b1, pat(300 + k), 1'b0, 1'b0);
        cyc(1'b1, pat(399), 1'b0, 1'b0);
        chk_status("both_set");
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk_status("clr_both");

        while (q.size() != 0)
            cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk_status("clr_vs_unf");

        for (int k = 0; k < 3; k++)
            cyc(1'b1, pat(500 + k), 1'b0, 1'b0);
        chk_status("pre_rst");
        do_reset();
        chk_status("mid_rst");
        cyc(1'b1, v1234, 1'b0, 1'b0);
        chk_status("post_rst");
        check("post_rst_data", rd_data, v1234);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk_status("final");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
